fifo_wr_adapter: RTL and testbench

Write-side front end for the async FIFO, one stage upstream of the FIFO write controller in the `w_clk` domain. Converts a valid/ready stream into the FIFO's `winc`/`wdata` push interface through a 2-entry skid buffer, so upstream logic never has to look at `wfull` combinationally. Keeps write and stall statistics for debug.

---
 rtl/fifo_wr_adapter_if.sv | 22 ++
 rtl/fifo_wr_adapter.sv | 83 ++++++++
 tb/tb_fifo_wr_adapter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/fifo_wr_adapter_if.sv
// Stream-in / FIFO-push handshake bundle for fifo_wr_adapter.
// The slave modport is the adapter side; the master modport is the environment side.
interface fifo_wr_adapter_if #(
   parameter int DATA_WIDTH = 8
);
   logic                  s_valid;
   logic [DATA_WIDTH-1:0] s_data;
   logic                  s_ready;
   logic                  winc;
   logic [DATA_WIDTH-1:0] wdata;
   logic                  wfull;

   modport master (
      output s_valid, s_data, wfull,
      input  s_ready, winc, wdata
   );

   modport slave (
      input  s_valid, s_data, wfull,
      output s_ready, winc, wdata
   );
endinterface

// File: rtl/fifo_wr_adapter.sv
// Write-side skid-buffer front end for the async FIFO: valid/ready stream in,
// winc/wdata push out, plus word and stall statistics.
module fifo_wr_adapter #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                 w_clk,
   input  logic                 w_rst,
   fifo_wr_adapter_if.slave     bus,
   input  logic                 cnt_clr,
   output logic [CNT_WIDTH-1:0] word_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt,
   output logic                 busy
);
   typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

   state_t                state;
   state_t                state_nxt;
   logic [DATA_WIDTH-1:0] out_data;
   logic [DATA_WIDTH-1:0] skid_data;
   logic                  out_valid;
   logic                  push;
   logic                  pop;

   assign push = bus.s_valid & bus.s_ready;
   // The write controller gates winc with its own full flag, so this is its increment.
   assign pop  = out_valid & ~bus.wfull;

   always_ff @(posedge w_clk) begin
      if (w_rst) state <= EMPTY;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         EMPTY: if (push) state_nxt = ONE;
         ONE: begin
            if (push & ~pop)      state_nxt = TWO;
            else if (~push & pop) state_nxt = EMPTY;
         end
         TWO:   if (pop) state_nxt = ONE;
         default: state_nxt = EMPTY;
      endcase
   end

   // s_ready is a pure state decode, keeping wfull and s_valid off the ready path.
   always_comb begin
      out_valid   = (state != EMPTY);
      busy        = out_valid;
      bus.s_ready = (state != TWO) & ~w_rst;
      bus.winc    = out_valid;
      bus.wdata   = out_data;
   end

   always_ff @(posedge w_clk) begin
      if (w_rst) begin
         out_data  <= '0;
         skid_data <= '0;
      end else begin
         case (state)
            EMPTY: if (push) out_data <= bus.s_data;
            ONE: begin
               if (push & pop) out_data  <= bus.s_data;
               else if (push)  skid_data <= bus.s_data;
            end
            TWO:   if (pop) out_data <= skid_data;
            default: ;
         endcase
      end
   end

   always_ff @(posedge w_clk) begin
      if (w_rst | cnt_clr) begin
         word_cnt  <= '0;
         stall_cnt <= '0;
      end else begin
         if (pop) word_cnt <= word_cnt + CNT_WIDTH'(1);
         if (out_valid & bus.wfull & (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      end
   end
endmodule

// File: tb/tb_fifo_wr_adapter.sv
// Directed and random bench for fifo_wr_adapter; a 16-bit and a 4-bit counter
// build run side by side on identical stimulus against a queue-based model.
module tb_fifo_wr_adapter;
   logic clk = 1'b0;
   logic rst;
   logic clr;

   always #5 clk = ~clk;

   fifo_wr_adapter_if #(.DATA_WIDTH(8)) bus16 ();
   fifo_wr_adapter_if #(.DATA_WIDTH(8)) bus4 ();

   logic [15:0] word16, stall16;
   logic [3:0]  word4, stall4;
   logic        busy16, busy4;

   assign bus4.s_valid = bus16.s_valid;
   assign bus4.s_data  = bus16.s_data;
   assign bus4.wfull   = bus16.wfull;

   fifo_wr_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(16)) dut16 (
      .w_clk(clk), .w_rst(rst), .bus(bus16), .cnt_clr(clr),
      .word_cnt(word16), .stall_cnt(stall16), .busy(busy16)
   );

   fifo_wr_adapter #(.DATA_WIDTH(8), .CNT_WIDTH(4)) dut4 (
      .w_clk(clk), .w_rst(rst), .bus(bus4), .cnt_clr(clr),
      .word_cnt(word4), .stall_cnt(stall4), .busy(busy4)
   );

   // Model: words held in the adapter, oldest first, plus raw event tallies.
   logic [7:0] q[$];
   logic [7:0] m_wdata;
   int         pops;
   int         stalls;
   int         n_tests = 0;
   int         n_fail  = 0;

   task automatic chk(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   function automatic int sat(input int v, input int lim);
      return (v > lim) ? lim : v;
   endfunction

   task automatic model_update();
      bit do_pop, do_push;
      if (rst) begin
         q.delete();
         pops    = 0;
         stalls  = 0;
         m_wdata = 8'h00;
      end else begin
         do_pop  = (q.size() > 0) && !bus16.wfull;
         do_push = bus16.s_valid && (q.size() < 2);
         if ((q.size() > 0) && bus16.wfull) stalls++;
         if (do_pop) begin
            void'(q.pop_front());
            pops++;
         end
         if (do_push) q.push_back(bus16.s_data);
         if (q.size() > 0) m_wdata = q[0];
         if (clr) begin
            pops   = 0;
            stalls = 0;
         end
      end
   endtask

   task automatic compare();
      chk("s_ready",    bus16.s_ready, int'((q.size() < 2) && !rst));
      chk("winc",       bus16.winc,    int'(q.size() > 0));
      chk("wdata",      bus16.wdata,   m_wdata);
      chk("busy",       busy16,        int'(q.size() > 0));
      chk("word_cnt",   word16,        pops % 65536);
      chk("stall_cnt",  stall16,       sat(stalls, 65535));
      chk("winc_w4",    bus4.winc,     int'(q.size() > 0));
      chk("wdata_w4",   bus4.wdata,    m_wdata);
      chk("busy_w4",    busy4,         int'(q.size() > 0));
      chk("word_cnt4",  word4,         pops % 16);
      chk("stall_cnt4", stall4,        sat(stalls, 15));
   endtask

   task automatic step();
      @(posedge clk);
      model_update();
      #2;
      compare();
   endtask

   task automatic drive(input bit v, input logic [7:0] d, input bit f,
                        input bit c, input bit r);
      bus16.s_valid = v;
      bus16.s_data  = d;
      bus16.wfull   = f;
      clr           = c;
      rst           = r;
   endtask

   initial begin
      drive(0, 8'h00, 0, 0, 1);
      q.delete();
      pops = 0;
      stalls = 0;
      m_wdata = 8'h00;
      for (int i = 0; i < 3; i++) step();
      chk("rst_winc",   bus16.winc, 0);
      chk("rst_wdata",  bus16.wdata, 0);
      chk("rst_busy",   busy16, 0);
      chk("rst_word",   word16, 0);
      chk("rst_stall",  stall16, 0);
      chk("rst_sready", bus16.s_ready, 0);

      drive(0, 8'h00, 0, 0, 0);
      #1;
      chk("release_sready", bus16.s_ready, 1);

      // Sustained stream 0x01..0x10 with no backpressure
      for (int i = 1; i <= 16; i++) begin
         drive(1, 8'(i), 0, 0, 0);
         step();
         if (i == 1) begin
            chk("first_winc",  bus16.winc, 1);
            chk("first_wdata", bus16.wdata, 8'h01);
         end
      end
      drive(0, 8'h00, 0, 0, 0);
      step();
      step();
      chk("stream_word",  word16, 16);
      chk("stream_stall", stall16, 0);

      // Backpressure: wfull rises once 0xA0 is on wdata
      drive(0, 8'h00, 0, 1, 0);
      step();
      drive(1, 8'hA0, 0, 0, 0);
      step();
      chk("bp_a0", bus16.wdata, 8'hA0);
      drive(1, 8'hA1, 1, 0, 0);
      step();
      chk("bp_sready", bus16.s_ready, 0);
      chk("bp_hold",   bus16.wdata, 8'hA0);
      drive(1, 8'hA2, 1, 0, 0);
      for (int i = 0; i < 4; i++) step();
      chk("bp_stall5", stall16, 5);
      drive(1, 8'hA2, 0, 0, 0);
      step();
      chk("bp_a1", bus16.wdata, 8'hA1);
      chk("bp_ready_back", bus16.s_ready, 1);
      step();
      chk("bp_a2", bus16.wdata, 8'hA2);
      drive(0, 8'h00, 0, 0, 0);
      step();
      chk("bp_word", word16, 3);
      chk("bp_stall_final", stall16, 5);

      // Saturation of the 4-bit stall counter, then clear racing a pop
      drive(0, 8'h00, 0, 1, 0);
      step();
      drive(1, 8'h33, 1, 0, 0);
      step();
      drive(0, 8'h00, 1, 0, 0);
      for (int i = 0; i < 20; i++) step();
      chk("sat_stall4",  stall4, 15);
      chk("sat_stall16", stall16, 20);
      drive(0, 8'h00, 0, 1, 0);
      step();
      chk("clr_pop_word16", word16, 0);
      chk("clr_pop_word4",  word4, 0);
      chk("clr_pop_winc",   bus16.winc, 0);

      // Reset while holding two words
      drive(1, 8'h55, 1, 0, 0);
      step();
      drive(1, 8'h66, 1, 0, 0);
      step();
      chk("two_busy",   busy16, 1);
      chk("two_sready", bus16.s_ready, 0);
      drive(0, 8'h00, 1, 0, 1);
      step();
      chk("midrst_winc",  bus16.winc, 0);
      chk("midrst_busy",  busy16, 0);
      chk("midrst_word",  word16, 0);
      chk("midrst_stall", stall16, 0);
      drive(1, 8'h77, 0, 0, 0);
      step();
      chk("post_rst_wdata", bus16.wdata, 8'h77);
      chk("post_rst_winc",  bus16.winc, 1);
      drive(0, 8'h00, 0, 0, 0);
      step();
      chk("post_rst_empty", bus16.winc, 0);
      chk("post_rst_word",  word16, 1);

      // Random valid/full traffic with occasional clear and reset
      for (int i = 0; i < 10000; i++) begin
         drive($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 3) == 0,
               $urandom_range(0, 499) == 0, $urandom_range(0, 1999) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
